// File: rtl/network_transmit_control_pkg.sv
// Shared constants and state encoding for the network transmit controller.
package network_transmit_control_pkg;
  localparam int DESC_W    = 57;
  localparam int WORD_W    = 134;
  localparam int TAG_MSB   = 56;
  localparam int TAG_LSB   = 9;
  localparam int BUFID_MSB = 8;
  localparam int TAG_W     = TAG_MSB - TAG_LSB + 1;
  localparam int BUFID_W   = BUFID_MSB + 1;
  localparam int HEAD      = 133;
  localparam int TAIL      = 132;
  localparam int TAG_HI    = 127;
  localparam int TAG_LO    = 80;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_TRANS,
    S_RELEASE,
    S_GAP
  } tx_state_e;
endpackage

// File: rtl/network_transmit_control_if.sv
// Descriptor, packet-buffer and port signals of the transmit controller.
interface network_transmit_control_if;
  import network_transmit_control_pkg::*;

  logic [DESC_W-1:0]  iv_descriptor;
  logic               i_descriptor_wr;
  logic               o_descriptor_ready;
  logic [BUFID_W-1:0] ov_pkt_bufid;
  logic               o_pkt_rd_req;
  logic               i_pkt_rd_ack;
  logic [WORD_W-1:0]  iv_pkt_data;
  logic               i_pkt_data_wr;
  logic [WORD_W-1:0]  ov_data;
  logic               o_data_wr;
  logic [BUFID_W-1:0] ov_bufid_release;
  logic               o_bufid_release_wr;
  logic [31:0]        ov_tx_pkt_cnt;
  logic [15:0]        ov_err_cnt;

  // master is the controller itself, slave is its surrounding environment
  modport master (
    input  iv_descriptor, i_descriptor_wr, i_pkt_rd_ack, iv_pkt_data, i_pkt_data_wr,
    output o_descriptor_ready, ov_pkt_bufid, o_pkt_rd_req, ov_data, o_data_wr,
           ov_bufid_release, o_bufid_release_wr, ov_tx_pkt_cnt, ov_err_cnt
  );

  modport slave (
    output iv_descriptor, i_descriptor_wr, i_pkt_rd_ack, iv_pkt_data, i_pkt_data_wr,
    input  o_descriptor_ready, ov_pkt_bufid, o_pkt_rd_req, ov_data, o_data_wr,
           ov_bufid_release, o_bufid_release_wr, ov_tx_pkt_cnt, ov_err_cnt
  );
endinterface

// File: rtl/network_transmit_control.sv
// Pops one descriptor, fetches its packet, forwards words with optional TSN tag
// insertion, releases the buffer and enforces the inter-frame gap.
module network_transmit_control
  import network_transmit_control_pkg::*;
#(
  parameter int P_IFG_CYCLES = 3,
  parameter int P_TAG_INSERT = 1
) (
  input logic                        i_clk,
  input logic                        i_rst,
  network_transmit_control_if.master bus
);
  localparam logic [7:0] IFG_LAST = (P_IFG_CYCLES > 0) ? 8'(P_IFG_CYCLES - 1) : 8'd0;

  tx_state_e          state, state_nxt;
  logic [TAG_W-1:0]   tag_q;
  logic [BUFID_W-1:0] bufid_q;
  logic               first_word, tail_done;
  logic [7:0]         gap_cnt;
  logic [WORD_W-1:0]  data_q, word_fwd;
  logic               data_wr_q;
  logic [31:0]        tx_cnt;
  logic [15:0]        err_cnt;
  logic               ready, word_ok, w_head, w_tail;
  logic               head_err, drop_err, desc_err;
  logic [1:0]         err_inc;
  logic [16:0]        err_sum;

  assign ready    = (state == S_IDLE) && !i_rst;
  assign w_head   = bus.iv_pkt_data[HEAD];
  assign w_tail   = bus.iv_pkt_data[TAIL];
  // once the tail is in, the rest of TRANS only waits for it to leave the port
  assign word_ok  = bus.i_pkt_data_wr && (state == S_TRANS) && !tail_done;
  assign drop_err = bus.i_pkt_data_wr && !word_ok;
  assign head_err = word_ok && (first_word ? !w_head : w_head);
  assign desc_err = bus.i_descriptor_wr && (state != S_IDLE);
  assign err_inc  = {1'b0, desc_err} + {1'b0, drop_err | head_err};
  assign err_sum  = {1'b0, err_cnt} + {15'd0, err_inc};

  // only a legitimate head word gets the tag; misplaced heads pass unchanged
  always_comb begin
    word_fwd = bus.iv_pkt_data;
    if (P_TAG_INSERT != 0 && first_word && w_head)
      word_fwd[TAG_HI:TAG_LO] = tag_q;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bus.i_descriptor_wr) state_nxt = S_REQ;
      S_REQ:     if (bus.i_pkt_rd_ack) state_nxt = S_TRANS;
      S_TRANS:   if (tail_done) state_nxt = S_RELEASE;
      S_RELEASE: state_nxt = (P_IFG_CYCLES == 0) ? S_IDLE : S_GAP;
      S_GAP:     if (gap_cnt == IFG_LAST) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      tag_q      <= '0;
      bufid_q    <= '0;
      first_word <= 1'b0;
      tail_done  <= 1'b0;
      gap_cnt    <= '0;
      data_q     <= '0;
      data_wr_q  <= 1'b0;
      tx_cnt     <= '0;
      err_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && bus.i_descriptor_wr) begin
        tag_q   <= bus.iv_descriptor[TAG_MSB:TAG_LSB];
        bufid_q <= bus.iv_descriptor[BUFID_MSB:0];
      end
      if (state == S_REQ)
        first_word <= 1'b1;
      else if (word_ok)
        first_word <= 1'b0;
      tail_done <= (state == S_TRANS) && (tail_done || (word_ok && w_tail));
      if (state == S_RELEASE)
        gap_cnt <= '0;
      else if (state == S_GAP)
        gap_cnt <= gap_cnt + 8'd1;
      data_wr_q <= word_ok;
      if (word_ok)
        data_q <= word_fwd;
      // bumped on the TRANS->RELEASE edge so it shows with the release strobe
      if (state == S_TRANS && tail_done)
        tx_cnt <= tx_cnt + 32'd1;
      if (err_inc != 2'd0)
        err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  assign bus.o_descriptor_ready = ready;
  assign bus.o_pkt_rd_req       = (state == S_REQ);
  assign bus.ov_pkt_bufid       = (state == S_REQ) ? bufid_q : '0;
  assign bus.ov_data            = data_q;
  assign bus.o_data_wr          = data_wr_q;
  assign bus.o_bufid_release_wr = (state == S_RELEASE);
  assign bus.ov_bufid_release   = (state == S_RELEASE) ? bufid_q : '0;
  assign bus.ov_tx_pkt_cnt      = tx_cnt;
  assign bus.ov_err_cnt         = err_cnt;
endmodule

// File: tb/tb_network_transmit_control.sv
// Directed bench: default instance (IFG 3, tag insert) plus a pass-through, zero-gap instance.
module tb_network_transmit_control;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int rel_pulses = 0;
  int wr_pulses = 0;
  int p0;

  always #5 i_clk = ~i_clk;

  network_transmit_control_if b ();
  network_transmit_control_if b0 ();

  network_transmit_control #(.P_IFG_CYCLES(3), .P_TAG_INSERT(1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .bus(b.master));
  network_transmit_control #(.P_IFG_CYCLES(0), .P_TAG_INSERT(0)) dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .bus(b0.master));

  always @(posedge i_clk) begin
    if (b.o_bufid_release_wr) rel_pulses <= rel_pulses + 1;
    if (b.o_data_wr) wr_pulses <= wr_pulses + 1;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!b.o_descriptor_ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_timeout", b.o_descriptor_ready, 1);
  endtask

  initial begin
    b.iv_descriptor = '0; b.i_descriptor_wr = 0; b.i_pkt_rd_ack = 0;
    b.iv_pkt_data = '0; b.i_pkt_data_wr = 0;
    b0.iv_descriptor = '0; b0.i_descriptor_wr = 0; b0.i_pkt_rd_ack = 0;
    b0.iv_pkt_data = '0; b0.i_pkt_data_wr = 0;

    // reset state
    tick(); tick();
    chk("rst_ready", b.o_descriptor_ready, 0);
    chk("rst_req", b.o_pkt_rd_req, 0);
    chk("rst_data_wr", b.o_data_wr, 0);
    chk("rst_rel", b.o_bufid_release_wr, 0);
    chk("rst_cnts", {b.ov_tx_pkt_cnt, b.ov_err_cnt}, 0);
    i_rst = 0;
    #1;
    chk("post_rst_ready", b.o_descriptor_ready, 1);

    // single 4-word packet, ack after 2 request cycles
    p0 = wr_pulses;
    b.iv_descriptor = {48'h123456789ABC, 9'h05}; b.i_descriptor_wr = 1;
    tick();
    b.i_descriptor_wr = 0;
    chk("t1_ready_low", b.o_descriptor_ready, 0);
    chk("t1_req1", {b.o_pkt_rd_req, b.ov_pkt_bufid}, {1'b1, 9'h05});
    tick();
    chk("t1_req2", {b.o_pkt_rd_req, b.ov_pkt_bufid}, {1'b1, 9'h05});
    b.i_pkt_rd_ack = 1;
    tick();
    b.i_pkt_rd_ack = 0;
    chk("t1_req_drop", b.o_pkt_rd_req, 0);
    b.iv_pkt_data = {2'b10, 4'h0, 128'h00112233445566778899AABBCCDDEEFF}; b.i_pkt_data_wr = 1;
    tick();
    chk("t1_head", {b.o_data_wr, b.ov_data},
        {1'b1, 2'b10, 4'h0, 128'h123456789ABC66778899AABBCCDDEEFF});
    b.iv_pkt_data = {2'b00, 4'h0, 128'h1};
    tick();
    chk("t1_w1", b.ov_data, {2'b00, 4'h0, 128'h1});
    b.iv_pkt_data = {2'b00, 4'h0, 128'h2};
    tick();
    chk("t1_w2", b.ov_data, {2'b00, 4'h0, 128'h2});
    b.iv_pkt_data = {2'b01, 4'h5, 128'h3};
    tick();
    b.i_pkt_data_wr = 0;
    chk("t1_tail", {b.o_data_wr, b.ov_data}, {1'b1, 2'b01, 4'h5, 128'h3});
    chk("t1_no_rel_yet", b.o_bufid_release_wr, 0);
    tick();
    chk("t1_rel", {b.o_bufid_release_wr, b.ov_bufid_release}, {1'b1, 9'h05});
    chk("t1_txcnt", b.ov_tx_pkt_cnt, 1);
    chk("t1_wr_pulses", wr_pulses - p0, 4);
    tick(); tick(); tick();
    chk("t1_gap_ready", b.o_descriptor_ready, 0);
    tick();
    chk("t1_ready_d6", b.o_descriptor_ready, 1);

    // back-to-back one-word packet, ack in the first request cycle
    b.iv_descriptor = {48'hAAAABBBBCCCC, 9'h1FF}; b.i_descriptor_wr = 1;
    tick();
    b.i_descriptor_wr = 0;
    chk("t2_accepted", b.o_pkt_rd_req, 1);
    b.i_pkt_rd_ack = 1;
    tick();
    b.i_pkt_rd_ack = 0;
    b.iv_pkt_data = {2'b11, 4'hF, 128'h0}; b.i_pkt_data_wr = 1;
    tick();
    b.i_pkt_data_wr = 0;
    chk("t2_word", b.ov_data, {2'b11, 4'hF, 128'hAAAABBBBCCCC00000000000000000000});
    tick();
    chk("t2_rel", {b.o_bufid_release_wr, b.ov_bufid_release, b.ov_tx_pkt_cnt},
        {1'b1, 9'h1FF, 32'd2});
    tick(); tick(); tick();
    chk("t2_ready_d5", b.o_descriptor_ready, 0);
    tick();
    chk("t2_ready_d6", b.o_descriptor_ready, 1);

    // descriptor strobe while busy is ignored and counted
    b.iv_descriptor = {48'hDEADBEEFCAFE, 9'h0A}; b.i_descriptor_wr = 1;
    tick();
    b.i_descriptor_wr = 0;
    b.i_pkt_rd_ack = 1;
    tick();
    b.i_pkt_rd_ack = 0;
    b.iv_pkt_data = {2'b10, 4'h0, 128'h0}; b.i_pkt_data_wr = 1;
    b.iv_descriptor = {48'hFFFFFFFFFFFF, 9'h1EE}; b.i_descriptor_wr = 1;
    tick();
    b.i_descriptor_wr = 0;
    chk("t3_head", b.ov_data, {2'b10, 4'h0, 128'hDEADBEEFCAFE00000000000000000000});
    b.iv_pkt_data = {2'b01, 4'h4, 128'h55};
    tick();
    b.i_pkt_data_wr = 0;
    chk("t3_tail", b.ov_data, {2'b01, 4'h4, 128'h55});
    tick();
    chk("t3_rel", {b.o_bufid_release_wr, b.ov_bufid_release, b.ov_tx_pkt_cnt},
        {1'b1, 9'h0A, 32'd3});
    chk("t3_err", b.ov_err_cnt, 1);

    // misplaced head flags: forwarded unchanged, counted
    wait_ready();
    b.iv_descriptor = {48'h0F0F0F0F0F0F, 9'h0B}; b.i_descriptor_wr = 1;
    tick();
    b.i_descriptor_wr = 0;
    b.i_pkt_rd_ack = 1;
    tick();
    b.i_pkt_rd_ack = 0;
    b.iv_pkt_data = {2'b00, 4'h0, 128'hAAAA}; b.i_pkt_data_wr = 1;
    tick();
    chk("t4_nohead", b.ov_data, {2'b00, 4'h0, 128'hAAAA});
    b.iv_pkt_data = {2'b10, 4'h1, 128'hBBBB};
    tick();
    chk("t4_late_head", b.ov_data, {2'b10, 4'h1, 128'hBBBB});
    b.iv_pkt_data = {2'b01, 4'h0, 128'hC};
    tick();
    b.i_pkt_data_wr = 0;
    tick();
    chk("t4_rel", {b.o_bufid_release_wr, b.ov_bufid_release}, {1'b1, 9'h0B});
    chk("t4_err", b.ov_err_cnt, 3);

    // pass-through, zero-gap instance: one-word packet
    b0.iv_descriptor = {48'h123456789ABC, 9'h33}; b0.i_descriptor_wr = 1;
    tick();
    b0.i_descriptor_wr = 0;
    b0.i_pkt_rd_ack = 1;
    tick();
    b0.i_pkt_rd_ack = 0;
    b0.iv_pkt_data = {2'b11, 4'h3, 128'hFEDCBA987654321001234567890ABCDE}; b0.i_pkt_data_wr = 1;
    tick();
    b0.i_pkt_data_wr = 0;
    chk("t5_word", {b0.o_data_wr, b0.ov_data},
        {1'b1, 2'b11, 4'h3, 128'hFEDCBA987654321001234567890ABCDE});
    chk("t5_no_rel_yet", b0.o_bufid_release_wr, 0);
    tick();
    chk("t5_rel", {b0.o_bufid_release_wr, b0.ov_bufid_release, b0.ov_tx_pkt_cnt},
        {1'b1, 9'h33, 32'd1});
    chk("t5_ready_d2", b0.o_descriptor_ready, 0);
    tick();
    chk("t5_ready_d3", {b0.o_descriptor_ready, b0.o_bufid_release_wr}, 2'b10);
    chk("t5_err", b0.ov_err_cnt, 0);

    // stray data in IDLE, then saturate the error counter
    wait_ready();
    p0 = wr_pulses;
    b.iv_pkt_data = {2'b11, 4'h0, 128'h99}; b.i_pkt_data_wr = 1;
    tick(); tick(); tick();
    chk("t6_dropped", wr_pulses - p0, 0);
    chk("t6_err", b.ov_err_cnt, 6);
    for (int i = 0; i < 65529; i++) tick();
    chk("t6_err_max", b.ov_err_cnt, 16'hFFFF);
    tick(); tick(); tick();
    b.i_pkt_data_wr = 0;
    chk("t6_err_sat", b.ov_err_cnt, 16'hFFFF);
    chk("t6_no_wr", b.o_data_wr, 0);

    // reset in the middle of a packet
    wait_ready();
    b.iv_descriptor = {48'h111111111111, 9'h07}; b.i_descriptor_wr = 1;
    tick();
    b.i_descriptor_wr = 0;
    b.i_pkt_rd_ack = 1;
    tick();
    b.i_pkt_rd_ack = 0;
    b.iv_pkt_data = {2'b10, 4'h0, 128'h1}; b.i_pkt_data_wr = 1;
    tick();
    b.iv_pkt_data = {2'b00, 4'h0, 128'h2};
    tick();
    b.i_pkt_data_wr = 0;
    p0 = rel_pulses;
    i_rst = 1;
    #1;
    chk("t7_ready_in_rst", b.o_descriptor_ready, 0);
    tick();
    chk("t7_outs_rst", {b.o_data_wr, b.o_pkt_rd_req, b.o_bufid_release_wr, b.o_descriptor_ready}, 0);
    chk("t7_data_rst", b.ov_data, 0);
    chk("t7_cnts_rst", {b.ov_tx_pkt_cnt, b.ov_err_cnt, b0.ov_tx_pkt_cnt}, 0);
    i_rst = 0;
    #1;
    chk("t7_ready_after", {b.o_descriptor_ready, b0.o_descriptor_ready}, 2'b11);
    tick(); tick(); tick(); tick();
    chk("t7_no_release", rel_pulses - p0, 0);
    chk("t7_idle_ready", b.o_descriptor_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/network_transmit_control.md
# network_transmit_control

Downstream stage of the network queue management block. It pops one 57-bit descriptor (TSN tag plus buffer ID) at a time and requests the matching packet from the packet buffer. It forwards the returned 134-bit words to the network port, optionally writing the TSN tag into the head word. After each packet it releases the buffer ID and enforces a minimum inter-frame gap before accepting the next descriptor.

## Interface
Parameters:
- P_IFG_CYCLES, 3: idle cycles between packets, counted from the release pulse; legal range 0..255.
- P_TAG_INSERT, 1: 1 = head word bits [127:80] are replaced by the tsntag; 0 = words pass through unchanged.

Ports:
- i_clk  in  1  single clock.
- i_rst  in  1  synchronous, active-high reset.
- iv_descriptor  in  57  [56:9] tsntag, [8:0] bufid.
- i_descriptor_wr  in  1  one-cycle descriptor strobe.
- o_descriptor_ready  out  1  block can accept a descriptor.
- ov_pkt_bufid  out  9  buffer ID being read.
- o_pkt_rd_req  out  1  read request, held until acknowledged.
- i_pkt_rd_ack  in  1  one-cycle read acknowledge.
- iv_pkt_data  in  134  [133] head, [132] tail, [131:128] invalid-byte count, [127:0] data.
- i_pkt_data_wr  in  1  packet word valid.
- ov_data  out  134  word sent to the port.
- o_data_wr  out  1  port word valid.
- ov_bufid_release  out  9  buffer ID to free.
- o_bufid_release_wr  out  1  one-cycle release strobe.
- ov_tx_pkt_cnt  out  32  packets sent; wraps.
- ov_err_cnt  out  16  protocol errors; saturates at 0xFFFF.

## Operation
- State machine states: IDLE, REQ, TRANS, RELEASE, GAP.
- IDLE:
  - o_descriptor_ready=1 only in this state.
  - A descriptor is accepted when i_descriptor_wr=1 and o_descriptor_ready=1; tsntag and bufid are latched, then go to REQ.
  - i_descriptor_wr while ready=0 is ignored and increments ov_err_cnt.
- REQ:
  - o_pkt_rd_req=1 and ov_pkt_bufid=latched bufid, held until i_pkt_rd_ack=1, then go to TRANS.
- TRANS:
  - Every i_pkt_data_wr word is registered to ov_data with o_data_wr=1.
  - If P_TAG_INSERT=1 and head bit=1, bits [127:80] of that word are replaced by the tsntag.
  - The tail-bit word is forwarded, then go to RELEASE.
  - A word with head=1 but tail=0 at the end of a packet is not a valid tail: stay in TRANS.
  - Counted as a protocol error and forwarded unchanged:
    - head=1 on any word other than the first of the packet;
    - first word of the packet with head=0.
  - A single word with head=1 and tail=1 is a legal one-word packet.
- RELEASE:
  - One cycle: o_bufid_release_wr=1, ov_bufid_release=latched bufid, ov_tx_pkt_cnt += 1.
  - Go to GAP, or straight to IDLE if P_IFG_CYCLES=0.
- GAP: 8-bit counter counts P_IFG_CYCLES cycles, then go to IDLE.
- i_pkt_data_wr outside TRANS: word dropped, ov_err_cnt += 1.
- i_pkt_rd_ack outside REQ: ignored.
- Reset in any state (including mid-packet):
  - state returns to IDLE; the in-flight packet is abandoned with no release strobe;
  - counters clear.

## Timing
- Reset values:
  - o_descriptor_ready=0 during reset, 1 in the first cycle after reset;
  - all other outputs 0.
- Accept at cycle t: o_descriptor_ready=0 and o_pkt_rd_req=1 at t+1.
- Ack at cycle a: state is TRANS at a+1; a word arriving at a+1 is accepted.
- Data latency: input word at cycle d appears on ov_data/o_data_wr at d+1; no backpressure toward the port.
- Tail at cycle d:
  - tail word on ov_data at d+1;
  - release strobe and counter increment at d+2;
  - o_descriptor_ready=1 at d+3+P_IFG_CYCLES.
- Minimum descriptor-to-descriptor spacing: 5+P_IFG_CYCLES cycles for a one-word packet with ack in the same cycle as the request.

## Structure
- Shared package holds:
  - descriptor field offsets (TAG_MSB=56, TAG_LSB=9, BUFID_MSB=8);
  - word flag bit positions (HEAD=133, TAG_HI=127, TAG_LO=80, TAIL=132);
  - the state enum.
- No sub-module is needed: FSM, output register and counters in one module of about 200 lines.

## Test plan
- Single packet: descriptor tsntag=0x123456789ABC, bufid=0x05; ack after 2 cycles; 4 words (head on word 0, tail on word 3).
  - Response: o_pkt_rd_req held 2 cycles with ov_pkt_bufid=0x05.
  - Head word bits [127:80]=0x123456789ABC; 4 o_data_wr pulses.
  - ov_bufid_release=0x05 one cycle after the tail leaves; ov_tx_pkt_cnt=1.
- Back-to-back descriptors with P_IFG_CYCLES=3: second ready edge lands exactly 6 cycles after the first tail input; the second descriptor is accepted.
- Descriptor while busy: i_descriptor_wr in TRANS is ignored, ov_err_cnt=1, the current packet completes intact.
- One-word packet (head=1, tail=1):
  - forwarded at d+1, released at d+2;
  - with P_TAG_INSERT=0 the word is bit-identical to the input.
- Stray data in IDLE: 3 words with i_pkt_data_wr=1 → o_data_wr stays 0 and ov_err_cnt=3; then force 0xFFFF errors and check saturation.
- Reset mid-TRANS after word 1 → no release strobe; outputs and counters 0 during reset; o_descriptor_ready=1 in the first cycle after reset.
